// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle width and field offsets, and
// the halt/drain FSM state encoding.
package pipeline_pkg;

  localparam int NB_CTRL = 21;

  // Control bundle field offsets, LSB first
  localparam int CTRL_REG_DST_RD     = 0;
  localparam int CTRL_JUMP           = 1;
  localparam int CTRL_JAL            = 2;
  localparam int CTRL_BRANCH         = 3;
  localparam int CTRL_NEQ_BRANCH     = 4;
  localparam int CTRL_MEM_READ       = 5;
  localparam int CTRL_MEM_TO_REG     = 6;
  localparam int CTRL_UNIT_ALU_OP    = 7;   // 2 bits
  localparam int CTRL_MEM_WRITE      = 9;
  localparam int CTRL_ALU_SRC        = 10;
  localparam int CTRL_REG_WRITE      = 11;
  localparam int CTRL_EXTENSION_MODE = 12;  // 2 bits
  localparam int CTRL_SIZE_FILTER    = 14;  // 2 bits
  localparam int CTRL_SIZE_FILTERL   = 16;  // 2 bits
  localparam int CTRL_ZERO_EXTEND    = 18;
  localparam int CTRL_LUI            = 19;
  localparam int CTRL_JALR           = 20;

  localparam int NB_DRAIN_CNT = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_t;

endpackage

// File: rtl/halt_drain_fsm.sv
// Halt sequencer: after a halt enters EX, waits DRAIN_CYCLES enabled cycles
// for the pipeline to empty, then raises a sticky o_halted.
module halt_drain_fsm
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_enable,
  input  logic i_flush,
  input  logic i_halt,
  output logic o_run,
  output logic o_halted
);

  halt_state_t             r_state;
  logic [NB_DRAIN_CNT-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_RUN;
      r_cnt    <= '0;
      o_halted <= 1'b0;
    end else if (i_enable) begin
      case (r_state)
        ST_RUN: begin
          if (i_halt && !i_flush) begin
            r_state <= ST_DRAIN;
            r_cnt   <= NB_DRAIN_CNT'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          // Count saturates at zero; the step that reaches zero ends the drain
          if (r_cnt <= 3'd1) begin
            r_cnt    <= '0;
            r_state  <= ST_HALTED;
            o_halted <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_HALTED: begin
          o_halted <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign o_run = (r_state == ST_RUN);

endmodule

// File: rtl/latch_id_ex.sv
// ID/EX pipeline latch with flush squashing and halt drain sequencing.
// Optional flush statistics counter enabled by macro LATCH_ID_EX_STATS_EN.
module latch_id_ex
  import pipeline_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDR      = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic               i_halt,
  input  logic [NB_DATA-1:0] i_pc4,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [NB_ADDR-1:0] i_rs,
  input  logic [NB_ADDR-1:0] i_rt,
  input  logic [NB_ADDR-1:0] i_rd,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_pc4,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_ADDR-1:0] o_rs,
  output logic [NB_ADDR-1:0] o_rt,
  output logic [NB_ADDR-1:0] o_rd,
  output logic               o_valid,
  output logic               o_halt,
  output logic               o_halted
`ifdef LATCH_ID_EX_STATS_EN
  ,
  output logic [15:0]        o_flush_count
`endif
);

  logic               w_run;
  logic               w_squash;
  logic [NB_CTRL-1:0] r_ctrl;
  logic [NB_DATA-1:0] r_pc4, r_rs_data, r_rt_data, r_imm;
  logic [NB_ADDR-1:0] r_rs, r_rt, r_rd;
  logic               r_valid, r_halt;

  halt_drain_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_halt_drain_fsm (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_enable  (i_enable),
    .i_flush   (i_flush),
    .i_halt    (i_halt),
    .o_run     (w_run),
    .o_halted  (o_halted)
  );

  // Control and qualifiers become a bubble on flush or once halting has begun
  assign w_squash = i_flush || !w_run;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ctrl    <= '0;
      r_pc4     <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_valid   <= 1'b0;
      r_halt    <= 1'b0;
    end else if (i_enable) begin
      r_pc4     <= i_pc4;
      r_rs_data <= i_rs_data;
      r_rt_data <= i_rt_data;
      r_imm     <= i_imm;
      r_rs      <= i_rs;
      r_rt      <= i_rt;
      r_rd      <= i_rd;
      r_ctrl    <= w_squash ? '0 : i_ctrl;
      r_valid   <= w_squash ? 1'b0 : i_valid;
      r_halt    <= w_squash ? 1'b0 : i_halt;
    end
  end

  assign o_ctrl    = r_ctrl;
  assign o_pc4     = r_pc4;
  assign o_rs_data = r_rs_data;
  assign o_rt_data = r_rt_data;
  assign o_imm     = r_imm;
  assign o_rs      = r_rs;
  assign o_rt      = r_rt;
  assign o_rd      = r_rd;
  assign o_valid   = r_valid;
  assign o_halt    = r_halt;

`ifdef LATCH_ID_EX_STATS_EN
  logic [15:0] r_flush_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_flush_count <= '0;
    end else if (i_enable && i_flush && (r_flush_count != 16'hFFFF)) begin
      r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign o_flush_count = r_flush_count;
`endif

endmodule

// File: doc/latch_id_ex.md
LATCH_ID_EX -- requirements
Module: latch_id_ex

Interface
REQ-001 SHALL expose parameters, one per line:
- NB_DATA, 32, data/PC width
- NB_ADDR, 5, register address width
- DRAIN_CYCLES, 3, enabled cycles between halt capture and o_halted (range 1..7)

REQ-002 SHALL have one clock and an asynchronous, active-low reset. Ports, one per line:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  stage advance (debug run/step)
- i_flush  in  1  squash instruction being captured
- i_valid  in  1  ID holds a real instruction
- i_ctrl  in  21  packed control bundle from the risk mux (layout per REQ-020)
- i_halt  in  1  halt decoded in ID
- i_pc4  in  NB_DATA  PC+4
- i_rs_data, i_rt_data  in  NB_DATA  register file reads
- i_imm  in  NB_DATA  extended immediate
- i_rs, i_rt, i_rd  in  NB_ADDR  register addresses
- o_ctrl  out  21  registered control bundle
- o_pc4, o_rs_data, o_rt_data, o_imm  out  NB_DATA  registered data
- o_rs, o_rt, o_rd  out  NB_ADDR  registered addresses
- o_valid  out  1  EX holds a real instruction
- o_halt  out  1  EX holds the halt instruction
- o_halted  out  1  pipeline drained after halt; sticky

Function
REQ-003 SHALL update registers only on rising i_clk with i_enable=1; with i_enable=0 all outputs, state and counters hold.
REQ-004 SHALL capture data, addresses and i_ctrl with 1-cycle latency in state RUN when i_enable=1 and i_flush=0; o_valid<=i_valid, o_halt<=i_halt.
REQ-005 SHALL, on i_flush=1 with i_enable=1, load o_ctrl=0, o_valid=0 and o_halt=0; data and address outputs still capture their inputs.
REQ-006 SHALL give i_flush priority over i_halt; a flushed halt is discarded and the state stays RUN.
REQ-007 SHALL implement FSM RUN -> DRAIN -> HALTED.
REQ-008 SHALL, in RUN with an enabled, unflushed i_halt=1 capture, move to DRAIN and load the drain counter with DRAIN_CYCLES.
REQ-009 SHALL, in DRAIN and HALTED, force o_ctrl=0, o_valid=0 and o_halt=0 on every enabled capture, ignoring i_ctrl, i_valid and i_halt.
REQ-010 SHALL decrement the drain counter once per enabled cycle in DRAIN; the cycle it reaches 0, the block SHALL enter HALTED and set o_halted=1.
REQ-011 SHALL hold HALTED with o_halted=1 until reset; i_flush has no effect on the FSM.
REQ-012 SHALL use 3-bit counter arithmetic with no wrap; the counter is never decremented below 0.

Reset
REQ-013 SHALL, on i_reset_n=0 and asynchronously, clear every output to 0, set FSM=RUN and clear the drain counter.
REQ-014 SHALL, on reset during DRAIN or HALTED, abandon the drain and return to RUN with o_halted=0.
REQ-015 SHALL release reset synchronously to i_clk; the first capture occurs on the first enabled edge after deassertion.

Configuration
REQ-016 SHALL, when macro LATCH_ID_EX_STATS_EN is defined, add output o_flush_count[15:0].
REQ-017 o_flush_count SHALL increment on each enabled capture with i_flush=1, saturate at 16'hFFFF, and reset to 0.
REQ-018 SHALL, without LATCH_ID_EX_STATS_EN, have neither the port nor its counter logic; all other behaviour is identical.

Structure
REQ-019 SHALL place NB_CTRL=21, the control-bundle field offsets and the FSM state encoding in shared package pipeline_pkg.
REQ-020 Bundle layout, LSB first: reg_dst_rd, jump, jal, branch, neq_branch, mem_read, mem_to_reg, unit_alu_op[2], mem_write, alu_src, reg_write, extension_mode[2], size_filter[2], size_filterL[2], zero_extend, lui, jalR.
REQ-021 SHALL contain one sub-module, halt_drain_fsm, owning the FSM, the drain counter and o_halted.

Verification
REQ-022 Enable=1, i_ctrl=21'h0A5A5, i_pc4=32'h104, i_valid=1 -> next edge: o_ctrl=21'h0A5A5, o_pc4=32'h104, o_valid=1.
REQ-023 Enable=0 for 5 cycles with changing inputs -> outputs unchanged; then enable=1 -> new values after 1 edge.
REQ-024 i_flush=1 and i_halt=1 together, i_ctrl=21'h1FFFFF -> o_ctrl=0, o_valid=0, o_halt=0, FSM stays RUN; stats build: o_flush_count=1.
REQ-025 Halt captured, DRAIN_CYCLES=3, enable toggling 1,0,1,1 -> o_halt=1 for one enabled cycle; o_halted rises after the 3rd enabled drain edge and stays 1 with o_ctrl=0.
REQ-026 i_reset_n=0 mid-DRAIN (counter=2) -> all outputs 0 immediately, FSM=RUN; a subsequent normal capture works.
REQ-027 Stats build, 65 540 enabled flushes -> o_flush_count=16'hFFFF.
